// File: rtl/synapse_unit.sv
`default_nettype none
// ============================================================================
// Module   : synapse_unit
// Purpose  : Delay-line synapse; pending spikes count down, then read wmem.
// Revision : 1.0
// ============================================================================
module synapse_unit #(
    parameter int DEPTH = 4,
    parameter int N_SRC = 16,
    localparam int SRC_W = $clog2(N_SRC),
    localparam int IDX_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             spike_in_valid,
    output logic             spike_in_ready,
    input  logic [SRC_W-1:0] spike_in_src,
    input  logic [15:0]      spike_in_delay,
    input  logic             wr_en,
    input  logic [SRC_W-1:0] wr_addr,
    input  logic [15:0]      wr_data,
    input  logic             soma_wait,
    output logic [15:0]      weight,
    output logic             weight_valid,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [SRC_W-1:0] src_q [DEPTH];
    logic [SRC_W-1:0] src_d [DEPTH];
    logic [15:0]      cnt_q [DEPTH];
    logic [15:0]      cnt_d [DEPTH];
    logic [15:0]      wmem_q [N_SRC];
    logic [15:0]      weight_q, weight_d;
    logic             weight_valid_q, weight_valid_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic             w_del_any;
    logic [IDX_W-1:0] w_del_idx;
    logic             w_free_any;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_deliver;
    logic             w_accept;

    assign spike_in_ready = (occ_q < OCC_W'(DEPTH));
    assign weight         = weight_q;
    assign weight_valid   = weight_valid_q;
    assign occupancy      = occ_q;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_del_any  = 1'b0;
        w_del_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (cnt_q[i] == 16'd0)) begin
                w_del_any = 1'b1;
                w_del_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_deliver = w_del_any && !soma_wait;
    assign w_accept  = spike_in_valid && spike_in_ready && w_free_any;

    always_comb begin
        valid_d        = valid_q;
        src_d          = src_q;
        cnt_d          = cnt_q;
        weight_d       = 16'd0;
        weight_valid_d = 1'b0;
        occ_d          = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (cnt_q[i] != 16'd0)) begin
                cnt_d[i] = cnt_q[i] - 16'd1;
            end
        end

        // Read of wmem_q here sees the pre-write value on a same-edge write.
        if (w_deliver) begin
            valid_d[w_del_idx] = 1'b0;
            weight_d           = wmem_q[src_q[w_del_idx]];
            weight_valid_d     = 1'b1;
        end

        // Free slot is chosen from registered state, so a slot vacated by
        // this cycle's delivery cannot be reused until the next cycle.
        if (w_accept) begin
            valid_d[w_free_idx] = 1'b1;
            src_d[w_free_idx]   = spike_in_src;
            cnt_d[w_free_idx]   = spike_in_delay;
        end

        if (kill) begin
            valid_d        = '0;
            weight_d       = 16'd0;
            weight_valid_d = 1'b0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            weight_q       <= 16'd0;
            weight_valid_q <= 1'b0;
            occ_q          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                src_q[i] <= '0;
                cnt_q[i] <= 16'd0;
            end
        end else begin
            valid_q        <= valid_d;
            src_q          <= src_d;
            cnt_q          <= cnt_d;
            weight_q       <= weight_d;
            weight_valid_q <= weight_valid_d;
            occ_q          <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                wmem_q[i] <= 16'd0;
            end
        end else if (wr_en) begin
            wmem_q[wr_addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_synapse_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_synapse_unit
// Purpose  : Scoreboard bench for synapse_unit against a due-time model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_synapse_unit;

    localparam int DEPTH = 4;
    localparam int N_SRC = 16;
    localparam int OCC_W = 3;

    logic        clk = 1'b0;
    logic        rst, kill, spike_in_valid, spike_in_ready;
    logic [3:0]  spike_in_src;
    logic [15:0] spike_in_delay;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        soma_wait;
    logic [15:0] weight;
    logic        weight_valid;
    logic [OCC_W-1:0] occupancy;

    always #5 clk = ~clk;

    synapse_unit #(.DEPTH(DEPTH), .N_SRC(N_SRC)) dut (
        .clk            (clk),
        .rst            (rst),
        .kill           (kill),
        .spike_in_valid (spike_in_valid),
        .spike_in_ready (spike_in_ready),
        .spike_in_src   (spike_in_src),
        .spike_in_delay (spike_in_delay),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .soma_wait      (soma_wait),
        .weight         (weight),
        .weight_valid   (weight_valid),
        .occupancy      (occupancy)
    );

    typedef struct {
        int          ed;
        logic [15:0] w;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          n_edge = 0;
    bit          mon_en = 1'b0;

    // Model: each pending spike becomes eligible once its absolute due edge
    // has passed; countdown saturation falls out of the comparison.
    bit          m_v   [DEPTH];
    int          m_src [DEPTH];
    longint      m_due [DEPTH];
    logic [15:0] m_wmem[N_SRC];
    int          m_occ = 0;

    always @(posedge clk) begin : model
        int del;
        int fr;
        n_edge++;
        if (rst === 1'b1) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
            for (int i = 0; i < N_SRC; i++) m_wmem[i] = 16'd0;
            mon_en = 1'b1;
        end else begin
            del = -1;
            fr  = -1;
            if (!soma_wait)
                for (int i = 0; i < DEPTH; i++)
                    if (del < 0 && m_v[i] && m_due[i] < longint'(n_edge)) del = i;
            for (int i = 0; i < DEPTH; i++)
                if (fr < 0 && !m_v[i]) fr = i;
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
            end else begin
                if (del >= 0) begin
                    sb_q.push_back('{n_edge, m_wmem[m_src[del]]});
                    m_v[del] = 1'b0;
                end
                if (spike_in_valid && m_occ < DEPTH && fr >= 0) begin
                    m_v[fr]   = 1'b1;
                    m_src[fr] = int'(spike_in_src);
                    m_due[fr] = longint'(n_edge) + longint'(spike_in_delay);
                end
            end
            if (wr_en) m_wmem[wr_addr] = wr_data;
        end
        m_occ = 0;
        for (int i = 0; i < DEPTH; i++) m_occ += int'(m_v[i]);
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (mon_en) begin
            tests++;
            if (occupancy !== OCC_W'(m_occ)) begin
                fails++;
                $display("FAIL occupancy edge %0d: got %0d want %0d", n_edge, occupancy, m_occ);
            end
            tests++;
            if (spike_in_ready !== (m_occ < DEPTH)) begin
                fails++;
                $display("FAIL ready edge %0d: got %b want %b", n_edge, spike_in_ready, (m_occ < DEPTH));
            end
            tests++;
            if (weight_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_pulse edge %0d: got weight %h want no pulse", n_edge, weight);
                end else begin
                    e = sb_q.pop_front();
                    if (e.ed != n_edge || weight !== e.w) begin
                        fails++;
                        $display("FAIL delivery edge %0d: got %h want %h at edge %0d", n_edge, weight, e.w, e.ed);
                    end
                end
            end else begin
                if (weight !== 16'd0 || weight_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_output edge %0d: got %h/%b want 0/0", n_edge, weight, weight_valid);
                end
                if (sb_q.size() > 0 && sb_q[0].ed <= n_edge) begin
                    tests++;
                    fails++;
                    $display("FAIL missed_pulse edge %0d: got none want %h", n_edge, sb_q[0].w);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [3:0] s, input logic [15:0] d);
        spike_in_valid = 1'b1;
        spike_in_src   = s;
        spike_in_delay = d;
        @(negedge clk);
        spike_in_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; kill = 1'b0; spike_in_valid = 1'b0; spike_in_src = '0;
        spike_in_delay = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; soma_wait = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wr(4'd3, 16'h0050);
        offer(4'd3, 16'd5);
        idle(10);

        for (int i = 0; i < 5; i++) offer(4'(i + 4), 16'd100);
        idle(110);

        wr(4'd5, 16'h1234);
        wr(4'd6, 16'h5678);
        offer(4'd5, 16'd3);
        offer(4'd6, 16'd2);
        idle(8);

        soma_wait = 1'b1;
        offer(4'd7, 16'd0);
        idle(9);
        soma_wait = 1'b0;
        idle(3);

        wr(4'd8, 16'h00AA);
        offer(4'd8, 16'd20);
        offer(4'd9, 16'd20);
        offer(4'd10, 16'd20);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        idle(25);
        offer(4'd8, 16'd0);
        idle(3);

        wr(4'd2, 16'h0007);
        offer(4'd2, 16'd0);
        wr(4'd2, 16'h0011);
        idle(3);
        offer(4'd2, 16'd0);
        idle(3);

        offer(4'd1, 16'd10);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(15);

        for (int c = 0; c < 3000; c++) begin
            spike_in_valid = ($urandom_range(0, 99) < 40);
            spike_in_src   = 4'($urandom_range(0, 15));
            spike_in_delay = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 60))
                                                         : 16'($urandom_range(0, 4));
            wr_en          = ($urandom_range(0, 99) < 20);
            wr_addr        = 4'($urandom_range(0, 15));
            wr_data        = 16'($urandom);
            soma_wait      = ($urandom_range(0, 99) < 25);
            kill           = ($urandom_range(0, 199) == 0);
            rst            = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        spike_in_valid = 1'b0; wr_en = 1'b0; soma_wait = 1'b0; kill = 1'b0; rst = 1'b0;

        guard = 0;
        while (m_occ != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        idle(2);
        tests++;
        if (m_occ != 0 || sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending/%0d queued want 0/0", m_occ, sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
